// File: rtl/spi_slave_enc_dec.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_enc_dec
// Description : Serial responder for the enc/dec link. It receives {msg,key}
//               on Mosi, runs one core handshake, then returns the result on
//               Miso with Out_clk as the per-bit strobe.
//               Optional macro SPI_SLAVE_TIMEOUT_EN adds a core-wait watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_enc_dec #(
    parameter int NB             = 4,
    parameter int NK             = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic               cs_enc_dec,
    input  logic               Mosi,
    output logic               Miso,
    output logic               Out_clk,
    output logic               core_start,
    output logic [32*NB-1:0]   core_msg,
    output logic [32*NK-1:0]   core_key,
    input  logic               core_done,
    input  logic [32*NB-1:0]   core_result,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int MSG_W   = 32 * NB;
    localparam int KEY_W   = 32 * NK;
    localparam int FRAME_W = MSG_W + KEY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] C_FRAME_BITS = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] C_MSG_BITS   = CNT_W'(MSG_W);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RECV      = 3'd1,
        S_WAIT_CORE = 3'd2,
        S_SEND      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [FRAME_W-1:0]  r_rx_sr;
    logic [MSG_W-1:0]    r_tx_sr;
    logic                r_armed;

`ifdef SPI_SLAVE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]     r_wait_cnt;
`else
    logic                w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_armed    <= 1'b1;
            Miso       <= 1'b0;
            Out_clk    <= 1'b0;
            core_start <= 1'b0;
            core_msg   <= '0;
            core_key   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef SPI_SLAVE_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            // A new frame needs cs seen low at least once since the last one
            if (!cs_enc_dec) begin
                r_armed <= 1'b1;
            end

            if (!cs_enc_dec && (r_state inside {S_RECV, S_WAIT_CORE, S_SEND})) begin
                frame_err <= 1'b1;
                Out_clk   <= 1'b0;
                Miso      <= 1'b0;
                r_cnt     <= '0;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        Out_clk <= 1'b0;
                        Miso    <= 1'b0;
                        if (cs_enc_dec && r_armed) begin
                            r_rx_sr <= {r_rx_sr[FRAME_W-2:0], Mosi};
                            r_cnt   <= C_CNT_ONE;
                            r_state <= S_RECV;
                        end
                    end

                    S_RECV: begin
                        if (r_cnt == C_FRAME_BITS) begin
                            core_msg   <= r_rx_sr[FRAME_W-1:KEY_W];
                            core_key   <= r_rx_sr[KEY_W-1:0];
                            core_start <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_WAIT_CORE;
`ifdef SPI_SLAVE_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end else begin
                            r_rx_sr <= {r_rx_sr[FRAME_W-2:0], Mosi};
                            r_cnt   <= r_cnt + C_CNT_ONE;
                        end
                    end

                    S_WAIT_CORE: begin
                        // MSB goes out on the same edge that captures the result
                        if (core_done) begin
                            r_tx_sr <= {core_result[MSG_W-2:0], 1'b0};
                            Miso    <= core_result[MSG_W-1];
                            Out_clk <= 1'b1;
                            r_cnt   <= C_CNT_ONE;
                            r_state <= S_SEND;
                        end
`ifdef SPI_SLAVE_TIMEOUT_EN
                        else if (r_wait_cnt == C_TO_LAST) begin
                            frame_err <= 1'b1;
                            r_armed   <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + TO_W'(1);
                        end
`endif
                    end

                    S_SEND: begin
                        if (r_cnt == C_MSG_BITS) begin
                            Out_clk    <= 1'b0;
                            Miso       <= 1'b0;
                            frame_done <= 1'b1;
                            r_armed    <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            Miso    <= r_tx_sr[MSG_W-1];
                            r_tx_sr <= r_tx_sr << 1;
                            r_cnt   <= r_cnt + C_CNT_ONE;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_enc_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_enc_dec
// Description : Scoreboard bench for spi_slave_enc_dec; the driver queues the
//               expected events, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_enc_dec;

    localparam int MSG_W = 128;
    localparam int KEY_W = 256;

    localparam int EV_START  = 0;
    localparam int EV_RESULT = 1;
    localparam int EV_DONE   = 2;
    localparam int EV_ERR    = 3;

    typedef struct {
        int           kind;
        logic [383:0] data;
    } ev_t;

    logic               clk;
    logic               rst_n;
    logic               cs;
    logic               mosi;
    logic               miso;
    logic               out_clk;
    logic               core_start;
    logic [MSG_W-1:0]   core_msg;
    logic [KEY_W-1:0]   core_key;
    logic               core_done;
    logic [MSG_W-1:0]   core_result;
    logic               frame_done;
    logic               frame_err;

    ev_t                exp_q[$];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 nbits    = 0;
    logic [MSG_W-1:0]   acc;
    logic               prev_oc  = 1'b0;
    logic [MSG_W-1:0]   last_msg = '0;
    logic [KEY_W-1:0]   last_key = '0;

    spi_slave_enc_dec #(.NB(4), .NK(8), .TIMEOUT_CYCLES(1024)) dut (
        .in_clk      (clk),
        .in_rst_n    (rst_n),
        .cs_enc_dec  (cs),
        .Mosi        (mosi),
        .Miso        (miso),
        .Out_clk     (out_clk),
        .core_start  (core_start),
        .core_msg    (core_msg),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic string kind_name(input int k);
        case (k)
            EV_START:  return "core_start_payload";
            EV_RESULT: return "miso_result_word";
            EV_DONE:   return "frame_done_event";
            default:   return "frame_err_bitcount";
        endcase
    endfunction

    task automatic push_ev(input int k, input logic [383:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int k, input logic [383:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got %s, required no event", kind_name(k));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 384'(k), 384'(e.kind));
            check(kind_name(e.kind), d, e.data);
        end
    endtask

    // Monitor: reconstructs DUT-side events and compares against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nbits   = 0;
                prev_oc = 1'b0;
            end else begin
                if (prev_oc && !out_clk) check("miso_low_after_stream", 384'(miso), 384'(0));
                prev_oc = out_clk;
                if (out_clk) begin
                    acc = {acc[MSG_W-2:0], miso};
                    nbits++;
                    if (nbits == MSG_W) begin
                        expect_ev(EV_RESULT, 384'(acc));
                        nbits = 0;
                    end
                end
                if (core_start) expect_ev(EV_START, {core_msg, core_key});
                if (frame_done) expect_ev(EV_DONE, '0);
                if (frame_err) begin
                    expect_ev(EV_ERR, 384'(nbits));
                    nbits = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx_abort: bits sent before cs drops (1..383, <0 none)
    // tx_abort: result bits seen before cs drops (1..127, <0 none)
    // spur_at : bit index at which a stray core_done is pulsed (<0 none)
    // rst_at  : result bits seen before async reset (>0 enables)
    task automatic run_frame(input logic [MSG_W-1:0] msg, input logic [KEY_W-1:0] key,
                             input logic [MSG_W-1:0] res, input int rx_abort,
                             input int tx_abort, input int spur_at, input int rst_at);
        logic [383:0] frame;
        frame = {msg, key};
        if (rx_abort < 0) push_ev(EV_START, frame);
        for (int i = 0; i < 384; i++) begin
            if (i == rx_abort) begin
                push_ev(EV_ERR, '0);
                cs = 1'b0;
                core_done = 1'b0;
                tick();
                check("rx_abort_msg_kept", 384'(core_msg), 384'(last_msg));
                check("rx_abort_key_kept", 384'(core_key), 384'(last_key));
                tick();
                return;
            end
            cs   = 1'b1;
            mosi = frame[383-i];
            if (i == spur_at) begin
                core_done   = 1'b1;
                core_result = ~res;
            end else begin
                core_done = 1'b0;
            end
            tick();
        end
        core_done = 1'b0;
        mosi = 1'($urandom);
        tick();
        check("start_latency", 384'(core_start), 384'(1));
        last_msg = msg;
        last_key = key;
        repeat ($urandom_range(0, 4)) tick();
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done   = 1'b0;
        core_result = ~res;
        check("first_outclk_latency", 384'(out_clk), 384'(1));
        if (tx_abort > 0) begin
            repeat (tx_abort - 1) tick();
            push_ev(EV_ERR, 384'(tx_abort));
            cs = 1'b0;
            tick();
            check("tx_abort_outclk_low", 384'(out_clk), 384'(0));
            tick();
            return;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) tick();
            #2 rst_n = 1'b0;
            #1;
            check("async_rst_strobes", 384'({miso, out_clk, core_start, frame_done, frame_err}), '0);
            check("async_rst_msg", 384'(core_msg), '0);
            check("async_rst_key", 384'(core_key), '0);
            exp_q.delete();
            last_msg = '0;
            last_key = '0;
            tick();
            rst_n = 1'b1;
            cs    = 1'b0;
            tick();
            return;
        end
        push_ev(EV_RESULT, 384'(res));
        push_ev(EV_DONE, '0);
        repeat (MSG_W - 1) tick();
        tick();
        check("frame_done_timing", 384'(frame_done), 384'(1));
        mosi = 1'b1;
        repeat (3) tick();
        cs = 1'b0;
        tick();
    endtask

    function automatic logic [MSG_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int sel;
        rst_n = 1'b0;
        cs = 1'b0;
        mosi = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        repeat (3) tick();
        check("reset_strobes", 384'({miso, out_clk, core_start, frame_done, frame_err}), '0);
        check("reset_msg", 384'(core_msg), '0);
        check("reset_key", 384'(core_key), '0);
        rst_n = 1'b1;
        tick();

        run_frame(128'h00112233445566778899aabbccddeeff,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, -1, -1, -1, 0);
        run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(), 100, -1, -1, 0);
        run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(), -1, -1, 50, 0);
        run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(), -1, 40, -1, 0);
        run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(), -1, -1, -1, 60);
        run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(), -1, -1, -1, 0);
        for (int f = 0; f < 6; f++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 1)
                run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(),
                          int'($urandom_range(1, 383)), -1, -1, 0);
            else if (sel == 2)
                run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(),
                          -1, int'($urandom_range(1, 127)), -1, 0);
            else
                run_frame(rnd128(), {rnd128(), rnd128()}, rnd128(),
                          -1, -1, int'($urandom_range(0, 383)), 0);
        end

        repeat (4) tick();
        check("queue_drained", 384'(exp_q.size()), '0);
        check("no_partial_stream", 384'(nbits), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
